// File: rtl/ring_link_pipe.sv
// Registered, backpressure-aware ring link stage with a latency-aged circular FIFO.
// Optional statistics counters are built only when RING_LINK_STATS_EN is defined.
module ring_link_pipe #(
    parameter int unsigned PACKET_SIZE  = 49,
    parameter int unsigned FIFO_DEPTH   = 4,
    parameter int unsigned LINK_LATENCY = 2,
    parameter int unsigned SKID_RESERVE = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [PACKET_SIZE-1:0]        up_packet_in,
    output logic                          up_backpressure_wr,
    output logic [PACKET_SIZE-1:0]        dn_packet_out,
    input  logic                          dn_backpressure_rd,
    output logic [$clog2(FIFO_DEPTH):0]   occupancy,
    output logic                          overflow_err,
    output logic [63:0]                   fwd_count,
    output logic [63:0]                   stall_cycles,
    output logic [31:0]                   drop_count
);

    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW = PtrW + 1;
    localparam logic [3:0]      AgeMax   = 4'(LINK_LATENCY);
    localparam logic [CntW-1:0] Full     = CntW'(FIFO_DEPTH);
    localparam logic [CntW-1:0] BpThresh = CntW'(FIFO_DEPTH - SKID_RESERVE);

    logic [PACKET_SIZE-1:0] mem [FIFO_DEPTH];
    logic [3:0]             age [FIFO_DEPTH];
    logic [PtrW-1:0]        rd_ptr;
    logic [PtrW-1:0]        wr_ptr;
    logic [CntW-1:0]        count;
    logic [CntW-1:0]        count_next;
    logic                   push;
    logic                   pop;
    logic                   accept;
    logic                   drop;
    logic                   eligible;

    always_comb begin
        push     = up_packet_in[PACKET_SIZE-1];
        eligible = (count != '0) && (age[rd_ptr] >= AgeMax);
        pop      = eligible && !dn_backpressure_rd;
        // A pop at the same edge frees the slot a full-FIFO push needs.
        accept   = push && ((count != Full) || pop);
        drop     = push && !accept;
        count_next = count + CntW'(accept) - CntW'(pop);
    end

    // Payload storage needs no reset: count gates every read.
    always_ff @(posedge clk) begin
        if (accept) begin
            mem[wr_ptr] <= up_packet_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr             <= '0;
            wr_ptr             <= '0;
            count              <= '0;
            dn_packet_out      <= '0;
            up_backpressure_wr <= 1'b0;
            overflow_err       <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                age[i] <= '0;
            end
        end else begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                if (accept && (wr_ptr == PtrW'(i))) begin
                    age[i] <= 4'd1;
                end else if (age[i] < AgeMax) begin
                    age[i] <= age[i] + 4'd1;
                end
            end
            if (accept) begin
                wr_ptr <= wr_ptr + PtrW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PtrW'(1);
            end
            dn_packet_out      <= pop ? mem[rd_ptr] : '0;
            count              <= count_next;
            up_backpressure_wr <= (count_next >= BpThresh);
            overflow_err       <= overflow_err | drop;
        end
    end

    assign occupancy = count;

`ifdef RING_LINK_STATS_EN
    logic        stall;
    logic [63:0] fwd_q;
    logic [63:0] stall_q;
    logic [31:0] drop_q;

    assign stall = eligible && dn_backpressure_rd;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fwd_q   <= '0;
            stall_q <= '0;
            drop_q  <= '0;
        end else begin
            if (pop)   fwd_q   <= fwd_q + 64'd1;
            if (stall) stall_q <= stall_q + 64'd1;
            if (drop)  drop_q  <= drop_q + 32'd1;
        end
    end

    assign fwd_count    = fwd_q;
    assign stall_cycles = stall_q;
    assign drop_count   = drop_q;
`else
    assign fwd_count    = '0;
    assign stall_cycles = '0;
    assign drop_count   = '0;
`endif

endmodule

// File: tb/tb_ring_link_pipe.sv
// Scoreboard bench for ring_link_pipe: directed stimulus pushes expected packets,
// a negedge monitor pops and compares every valid output pulse.
module tb_ring_link_pipe;

    localparam int PS = 49;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [PS-1:0] up_packet_in;
    logic          up_backpressure_wr;
    logic [PS-1:0] dn_packet_out;
    logic          dn_backpressure_rd;
    logic [2:0]    occupancy;
    logic          overflow_err;
    logic [63:0]   fwd_count;
    logic [63:0]   stall_cycles;
    logic [31:0]   drop_count;

    logic [PS-1:0] sb [$];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ring_link_pipe #(
        .PACKET_SIZE (PS),
        .FIFO_DEPTH  (4),
        .LINK_LATENCY(2),
        .SKID_RESERVE(2)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .up_packet_in      (up_packet_in),
        .up_backpressure_wr(up_backpressure_wr),
        .dn_packet_out     (dn_packet_out),
        .dn_backpressure_rd(dn_backpressure_rd),
        .occupancy         (occupancy),
        .overflow_err      (overflow_err),
        .fwd_count         (fwd_count),
        .stall_cycles      (stall_cycles),
        .drop_count        (drop_count)
    );

    function automatic logic [PS-1:0] mk(input logic [15:0] ts, input logic [15:0] src,
                                         input logic [15:0] dst);
        return {1'b1, ts, src, dst};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_stats(input string name, input logic [63:0] fwd,
                             input logic [63:0] stl, input logic [31:0] drp);
`ifdef RING_LINK_STATS_EN
        chk({name, "_fwd"}, fwd_count, fwd);
        chk({name, "_stall"}, stall_cycles, stl);
        chk({name, "_drop"}, {32'd0, drop_count}, {32'd0, drp});
`else
        chk({name, "_fwd"}, fwd_count, 64'd0 & fwd);
        chk({name, "_stall"}, stall_cycles, 64'd0 & stl);
        chk({name, "_drop"}, {32'd0, drop_count}, {32'd0, 32'd0 & drp});
`endif
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n              = 1'b0;
        up_packet_in       = '0;
        dn_backpressure_rd = 1'b0;
        sb.delete();
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    // Monitor: every valid output pulse must match the oldest expected packet.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && dn_packet_out[PS-1] === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_packet: got %0h expected none", dn_packet_out);
            end else begin
                chk("packet_data", 64'(dn_packet_out), 64'(sb.pop_front()));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [PS-1:0] p;
        logic [PS-1:0] junk;
        int exp_occ;
        int pushes;
        int pops;

        // Test 1: reset state and single-packet latency.
        do_reset();
        chk("rst_dn", 64'(dn_packet_out), 64'd0);
        chk("rst_bp", 64'(up_backpressure_wr), 64'd0);
        chk("rst_occ", 64'(occupancy), 64'd0);
        chk("rst_ovf", 64'(overflow_err), 64'd0);
        chk_stats("rst", 64'd0, 64'd0, 32'd0);
        p = mk(16'h0010, 16'h0001, 16'h0003);
        up_packet_in = p;
        sb.push_back(p);
        tick();
        up_packet_in = '0;
        chk("t1_e0_dn", 64'(dn_packet_out), 64'd0);
        chk("t1_e0_occ", 64'(occupancy), 64'd1);
        tick();
        chk("t1_e1_dn", 64'(dn_packet_out), 64'd0);
        tick();
        chk("t1_e2_dn", 64'(dn_packet_out), 64'(p));
        tick();
        chk("t1_e3_dn", 64'(dn_packet_out), 64'd0);
        chk_stats("t1", 64'd1, 64'd0, 32'd0);
        junk = 49'h0_ABCD_1234_5678;
        up_packet_in = junk;
        tick();
        up_packet_in = '0;
        chk("t1_invalid_occ", 64'(occupancy), 64'd0);
        tick();
        tick();
        chk("t1_invalid_dn", 64'(dn_packet_out), 64'd0);

        // Test 2: 20-packet stream, no downstream stall.
        do_reset();
        for (int k = 0; k < 22; k++) begin
            if (k < 20) begin
                p = mk(16'(k), 16'h0002, 16'h0005);
                up_packet_in = p;
                sb.push_back(p);
            end else begin
                up_packet_in = '0;
            end
            tick();
            pushes  = (k + 1 < 20) ? k + 1 : 20;
            pops    = (k - 1 < 0) ? 0 : ((k - 1 < 20) ? k - 1 : 20);
            exp_occ = pushes - pops;
            chk("t2_valid", 64'(dn_packet_out[PS-1]), (k >= 2 && k <= 21) ? 64'd1 : 64'd0);
            chk("t2_occ", 64'(occupancy), 64'(exp_occ));
            chk("t2_bp", 64'(up_backpressure_wr), (exp_occ >= 2) ? 64'd1 : 64'd0);
        end
        up_packet_in = '0;
        tick();
        chk("t2_drained", 64'(sb.size()), 64'd0);
        chk_stats("t2", 64'd20, 64'd0, 32'd0);

        // Test 3: downstream stall with three packets, then release.
        do_reset();
        dn_backpressure_rd = 1'b1;
        for (int k = 0; k < 3; k++) begin
            p = mk(16'h0100 + 16'(k), 16'h0007, 16'h0009);
            up_packet_in = p;
            sb.push_back(p);
            tick();
            chk("t3_occ", 64'(occupancy), 64'(k + 1));
            chk("t3_bp", 64'(up_backpressure_wr), (k >= 1) ? 64'd1 : 64'd0);
        end
        up_packet_in = '0;
        chk_stats("t3_e2", 64'd0, 64'd1, 32'd0);
        tick();
        tick();
        chk("t3_stalled_dn", 64'(dn_packet_out), 64'd0);
        chk_stats("t3_e4", 64'd0, 64'd3, 32'd0);
        dn_backpressure_rd = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("t3_release_valid", 64'(dn_packet_out[PS-1]), 64'd1);
        end
        tick();
        chk("t3_after_dn", 64'(dn_packet_out), 64'd0);
        chk("t3_after_occ", 64'(occupancy), 64'd0);
        chk("t3_after_bp", 64'(up_backpressure_wr), 64'd0);
        chk_stats("t3_end", 64'd3, 64'd3, 32'd0);

        // Test 4: upstream ignores stall, two packets dropped.
        do_reset();
        dn_backpressure_rd = 1'b1;
        for (int k = 0; k < 6; k++) begin
            p = mk(16'h0200 + 16'(k), 16'h0004, 16'h0006);
            up_packet_in = p;
            if (k < 4) sb.push_back(p);
            tick();
            chk("t4_occ", 64'(occupancy), (k < 4) ? 64'(k + 1) : 64'd4);
        end
        up_packet_in = '0;
        chk("t4_ovf", 64'(overflow_err), 64'd1);
        chk_stats("t4_full", 64'd0, 64'd4, 32'd2);
        dn_backpressure_rd = 1'b0;
        repeat (8) tick();
        chk("t4_drain_occ", 64'(occupancy), 64'd0);
        chk("t4_drained", 64'(sb.size()), 64'd0);
        chk("t4_ovf_sticky", 64'(overflow_err), 64'd1);
        chk_stats("t4_end", 64'd4, 64'd4, 32'd2);

        // Test 5: full FIFO with simultaneous push and pop.
        do_reset();
        dn_backpressure_rd = 1'b1;
        for (int k = 0; k < 4; k++) begin
            p = mk(16'h0300 + 16'(k), 16'h000A, 16'h000B);
            up_packet_in = p;
            sb.push_back(p);
            tick();
        end
        chk("t5_full_occ", 64'(occupancy), 64'd4);
        p = mk(16'h0304, 16'h000A, 16'h000B);
        up_packet_in = p;
        sb.push_back(p);
        dn_backpressure_rd = 1'b0;
        tick();
        up_packet_in = '0;
        chk("t5_pp_occ", 64'(occupancy), 64'd4);
        chk("t5_pp_ovf", 64'(overflow_err), 64'd0);
        chk("t5_pp_valid", 64'(dn_packet_out[PS-1]), 64'd1);
        chk_stats("t5_pp", 64'd1, 64'd2, 32'd0);
        repeat (8) tick();
        chk("t5_drain_occ", 64'(occupancy), 64'd0);
        chk("t5_drained", 64'(sb.size()), 64'd0);

        // Test 6: asynchronous reset with three entries held.
        do_reset();
        dn_backpressure_rd = 1'b1;
        for (int k = 0; k < 3; k++) begin
            up_packet_in = mk(16'h0400 + 16'(k), 16'h000C, 16'h000D);
            tick();
        end
        up_packet_in = '0;
        chk("t6_held_occ", 64'(occupancy), 64'd3);
        chk("t6_held_bp", 64'(up_backpressure_wr), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_async_dn", 64'(dn_packet_out), 64'd0);
        chk("t6_async_bp", 64'(up_backpressure_wr), 64'd0);
        chk("t6_async_occ", 64'(occupancy), 64'd0);
        chk("t6_async_ovf", 64'(overflow_err), 64'd0);
        chk_stats("t6_async", 64'd0, 64'd0, 32'd0);
        tick();
        rst_n = 1'b1;
        dn_backpressure_rd = 1'b0;
        p = mk(16'h0500, 16'h000E, 16'h000F);
        up_packet_in = p;
        sb.push_back(p);
        tick();
        up_packet_in = '0;
        chk("t6_e0_dn", 64'(dn_packet_out), 64'd0);
        tick();
        chk("t6_e1_dn", 64'(dn_packet_out), 64'd0);
        tick();
        chk("t6_e2_dn", 64'(dn_packet_out), 64'(p));
        repeat (6) tick();
        chk("t6_end_occ", 64'(occupancy), 64'd0);
        chk("t6_drained", 64'(sb.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
